// File: rtl/i2c_bus_arbiter_if.sv
// Handshake and bus signals between the per-sensor requesters, the shared
// I2C transaction engine and the i2c_bus_arbiter.
//   master : arbiter side (drives o_* signals)
//   slave  : requester/engine side (drives i_* signals)
interface i2c_bus_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   i_req;
   logic [7*N_REQ-1:0] i_addr;
   logic [N_REQ-1:0]   i_rw;
   logic [N_REQ-1:0]   i_clr_nr;
   logic               i_eng_done;
   logic               i_eng_nack;
   logic               o_start;
   logic [6:0]         o_addr;
   logic               o_rw;
   logic               o_busy;
   logic [N_REQ-1:0]   o_gnt;
   logic [N_REQ-1:0]   o_done;
   logic [N_REQ-1:0]   o_err;
   logic [N_REQ-1:0]   o_norespond;

   modport master (
      input  i_req, i_addr, i_rw, i_clr_nr, i_eng_done, i_eng_nack,
      output o_start, o_addr, o_rw, o_busy, o_gnt, o_done, o_err, o_norespond
   );

   modport slave (
      output i_req, i_addr, i_rw, i_clr_nr, i_eng_done, i_eng_nack,
      input  o_start, o_addr, o_rw, o_busy, o_gnt, o_done, o_err, o_norespond
   );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C transaction engine among N_REQ sensor requesters.
// Grants round-robin, issues one o_start per attempt, supervises each attempt
// with a timeout, retries failures and locks a requester out after MAX_RETRY
// consecutive failed attempts (sticky o_norespond, cleared by i_clr_nr).
// Build option: define ARB_FIXED_PRIO_EN to always grant the lowest eligible
// index instead of round-robin.
module i2c_bus_arbiter #(
   parameter int N_REQ       = 4,
   parameter int MAX_RETRY   = 10,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst,
   i2c_bus_arbiter_if.master bus
);
   localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RETRY, S_DONE} state_t;

   state_t           state_q;
   logic [SEL_W-1:0] sel_q;
`ifndef ARB_FIXED_PRIO_EN
   logic [SEL_W-1:0] rr_q;
`endif
   logic [3:0]       retry_q;
   logic [TO_W-1:0]  timeout_q;
   logic             start_q;
   logic [6:0]       addr_q;
   logic             rw_q;
   logic             busy_q;
   logic [N_REQ-1:0] gnt_q;
   logic [N_REQ-1:0] done_q;
   logic [N_REQ-1:0] err_q;
   logic [N_REQ-1:0] nr_q;

   logic [N_REQ-1:0] elig;
   logic [SEL_W-1:0] pick_d;
   logic             pick_vld;
   logic [3:0]       retry_inc;

   assign elig      = bus.i_req & ~nr_q;
   assign retry_inc = retry_q + 4'd1;

   // Pick the first eligible requester at or after the search origin.
   always_comb begin
      int idx;
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      pick_d   = '0;
      pick_vld = 1'b0;
      idx      = 0;
      for (int i = 0; i < N_REQ; i++) begin
`ifdef ARB_FIXED_PRIO_EN
         idx = i;
`else
         idx = (int'(rr_q) + i) % N_REQ;
`endif
         if (!pick_vld && elig[idx]) begin
            pick_d   = SEL_W'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   // Arbitration / attempt supervision FSM with registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
`ifndef ARB_FIXED_PRIO_EN
         rr_q      <= '0;
`endif
         retry_q   <= '0;
         timeout_q <= '0;
         start_q   <= 1'b0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         busy_q    <= 1'b0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= '0;
         nr_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; the later per-bit lockout set overrides this clear.
         start_q <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
         nr_q    <= nr_q & ~bus.i_clr_nr;
         case (state_q)
            S_IDLE: begin
               if (pick_vld) begin
                  sel_q   <= pick_d;
                  addr_q  <= bus.i_addr[7*int'(pick_d) +: 7];
                  rw_q    <= bus.i_rw[pick_d];
                  gnt_q   <= N_REQ'(1) << pick_d;
                  retry_q <= '0;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end
            end
            S_START: begin
               timeout_q <= '0;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               // Done wins over a coincident timeout expiry.
               if (bus.i_eng_done && !bus.i_eng_nack) begin
                  done_q[sel_q] <= 1'b1;
                  state_q       <= S_DONE;
               end else if (bus.i_eng_done || timeout_q == TO_W'(TIMEOUT_CYC - 1)) begin
                  retry_q <= retry_inc;
                  if (retry_inc == 4'(MAX_RETRY)) begin
                     nr_q[sel_q]   <= 1'b1;
                     done_q[sel_q] <= 1'b1;
                     err_q[sel_q]  <= 1'b1;
                     state_q       <= S_DONE;
                  end else begin
                     state_q <= S_RETRY;
                  end
               end else begin
                  timeout_q <= timeout_q + TO_W'(1);
               end
            end
            S_RETRY: begin
               start_q <= 1'b1;
               state_q <= S_START;
            end
            S_DONE: begin
               gnt_q   <= '0;
               busy_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
               rr_q    <= (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
`endif
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.o_start     = start_q;
   assign bus.o_addr      = addr_q;
   assign bus.o_rw        = rw_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_gnt       = gnt_q;
   assign bus.o_done      = done_q;
   assign bus.o_err       = err_q;
   assign bus.o_norespond = nr_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter (N_REQ=4, MAX_RETRY=10,
// TIMEOUT_CYC=16). Inputs are driven and outputs sampled on the falling edge.
module tb_i2c_bus_arbiter;
   localparam int N    = 4;
   localparam int MAXR = 10;
   localparam int T    = 16;

   logic i_clk = 1'b0;
   logic i_rst;
   int   checks = 0;
   int   errors = 0;

   i2c_bus_arbiter_if #(.N_REQ(N)) bus ();

   i2c_bus_arbiter #(.N_REQ(N), .MAX_RETRY(MAXR), .TIMEOUT_CYC(T)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, wanted completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge i_clk);
   endtask

   function automatic logic [N-1:0] oh(input int k);
      return N'(1) << k;
   endfunction

   function automatic logic [13:0] ev(input logic [N-1:0] gnt, input logic st,
                                      input logic [N-1:0] dn, input logic [N-1:0] er,
                                      input logic busy);
      return {gnt, st, dn, er, busy};
   endfunction

   function automatic logic [13:0] outs();
      return {bus.o_gnt, bus.o_start, bus.o_done, bus.o_err, bus.o_busy};
   endfunction

   // Requester selection rule: first eligible index at/after the origin.
   function automatic int pick(input logic [N-1:0] e, input int rr);
      int org;
      org = rr;
`ifdef ARB_FIXED_PRIO_EN
      org = 0;
`endif
      for (int i = 0; i < N; i++)
         if (e[(org + i) % N]) return (org + i) % N;
      return -1;
   endfunction

   task automatic do_reset();
      i_rst          = 1'b1;
      bus.i_req      = '0;
      bus.i_addr     = {7'h4D, 7'h3A, 7'h52, 7'h21};
      bus.i_rw       = 4'b1010;
      bus.i_clr_nr   = '0;
      bus.i_eng_done = 1'b0;
      bus.i_eng_nack = 1'b0;
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   // Engine response d cycles after the o_start cycle currently visible.
   task automatic serve(input int d, input logic nack);
      for (int i = 0; i < d - 1; i++) tick();
      bus.i_eng_done = 1'b1;
      bus.i_eng_nack = nack;
      tick();
      bus.i_eng_done = 1'b0;
      bus.i_eng_nack = 1'b0;
   endtask

   typedef struct packed {
      logic [N-1:0] req;
      logic [N-1:0] gnt_rr;
      logic [N-1:0] gnt_fp;
   } arb_vec_t;

   arb_vec_t tbl [10];

   // Random-phase reference model state.
   logic [N-1:0] req_d, rw_d, clr_d, clr_prev, nr_m, prev_e, set_v;
   logic [6:0]   addr_d [N];
   bit           dead [N];
   int           g, rr_m, fails, cyc, start_cyc, done_cyc, drv_cyc, wait_lo, wait_hi;
   bit           skip_idle, exp_err, drv_nack;
   logic [6:0]   exp_addr;
   logic         exp_rw;

   // Choose the engine's answer to the attempt whose o_start is visible now
   // and derive when the next start or completion must appear.
   task automatic plan_attempt();
      int  d, r;
      bit  tmo, nack;
      if (dead[g]) begin
         tmo  = ($urandom_range(0, 1) == 1);
         nack = 1'b1;
      end else begin
         tmo  = 1'b0;
         nack = ($urandom_range(0, 6) == 0);
      end
      d = $urandom_range(2, T + 1);
      if (tmo) begin
         r       = cyc + T + 1;
         drv_cyc = -1;
      end else begin
         r        = cyc + d;
         drv_cyc  = cyc + d - 1;
         drv_nack = nack;
      end
      wait_lo = cyc + 1;
      wait_hi = r - 1;
      if (!tmo && !nack) begin
         done_cyc  = r;
         exp_err   = 1'b0;
         start_cyc = -1;
      end else begin
         fails++;
         if (fails == MAXR) begin
            done_cyc  = r;
            exp_err   = 1'b1;
            start_cyc = -1;
         end else begin
            start_cyc = r + 1;
            done_cyc  = -1;
         end
      end
   endtask

   initial begin
      tbl[0] = '{4'b1111, 4'b0001, 4'b0001};
      tbl[1] = '{4'b1111, 4'b0010, 4'b0001};
      tbl[2] = '{4'b1111, 4'b0100, 4'b0001};
      tbl[3] = '{4'b1111, 4'b1000, 4'b0001};
      tbl[4] = '{4'b1111, 4'b0001, 4'b0001};
      tbl[5] = '{4'b1001, 4'b1000, 4'b0001};
      tbl[6] = '{4'b0110, 4'b0010, 4'b0010};
      tbl[7] = '{4'b0001, 4'b0001, 4'b0001};
      tbl[8] = '{4'b1100, 4'b0100, 4'b0100};
      tbl[9] = '{4'b0011, 4'b0001, 4'b0001};

      // Single request, ack 5 cycles after o_start.
      do_reset();
      check("reset_outs", outs(), 0);
      check("reset_nr", bus.o_norespond, 0);
      check("reset_addr", {bus.o_rw, bus.o_addr}, 0);
      bus.i_req = 4'b0001;
      tick();
      check("t1_grant", outs(), ev(4'b0001, 1, 0, 0, 1));
      check("t1_addr", {bus.o_rw, bus.o_addr}, {1'b0, 7'h21});
      serve(5, 1'b0);
      check("t1_done", outs(), ev(4'b0001, 0, 4'b0001, 0, 1));
      bus.i_req = '0;
      tick();
      check("t1_idle", outs(), 0);

      // Arbitration order table, every attempt acked.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         logic [N-1:0] eg;
`ifdef ARB_FIXED_PRIO_EN
         eg = tbl[i].gnt_fp;
`else
         eg = tbl[i].gnt_rr;
`endif
         bus.i_req = tbl[i].req;
         tick();
         check($sformatf("t2_grant%0d", i), outs(), ev(eg, 1, 0, 0, 1));
         serve(2, 1'b0);
         check($sformatf("t2_done%0d", i), outs(), ev(eg, 0, eg, 0, 1));
         bus.i_req = '0;
         tick();
      end

      // Three NACKs then ack: each restart preceded by one RETRY cycle.
      do_reset();
      bus.i_req = 4'b0100;
      tick();
      check("t3_grant", outs(), ev(4'b0100, 1, 0, 0, 1));
      for (int a = 0; a < 3; a++) begin
         serve(3, 1'b1);
         check($sformatf("t3_retry%0d", a), outs(), ev(4'b0100, 0, 0, 0, 1));
         tick();
         check($sformatf("t3_restart%0d", a), outs(), ev(4'b0100, 1, 0, 0, 1));
         check($sformatf("t3_addr%0d", a), {bus.o_rw, bus.o_addr}, {1'b0, 7'h3A});
      end
      serve(3, 1'b0);
      check("t3_done", outs(), ev(4'b0100, 0, 4'b0100, 0, 1));
      bus.i_req = '0;
      tick();

      // Silent engine: ten timeouts, lockout, ignored, then cleared.
      do_reset();
      bus.i_req = 4'b0010;
      tick();
      check("t4_grant", outs(), ev(4'b0010, 1, 0, 0, 1));
      check("t4_addr", {bus.o_rw, bus.o_addr}, {1'b1, 7'h52});
      for (int a = 1; a <= MAXR; a++) begin
         for (int i = 0; i < T; i++) tick();
         check($sformatf("t4_pre_expiry%0d", a), outs(), ev(4'b0010, 0, 0, 0, 1));
         if (a == MAXR) bus.i_clr_nr = 4'b0010;
         tick();
         bus.i_clr_nr = '0;
         if (a < MAXR) begin
            check($sformatf("t4_retry%0d", a), outs(), ev(4'b0010, 0, 0, 0, 1));
            tick();
            check($sformatf("t4_restart%0d", a), outs(), ev(4'b0010, 1, 0, 0, 1));
         end else begin
            check("t4_fail_done", outs(), ev(4'b0010, 0, 4'b0010, 4'b0010, 1));
            check("t4_nr_set_wins", bus.o_norespond, 4'b0010);
         end
      end
      for (int i = 0; i < 6; i++) tick();
      check("t4_locked_out", outs(), 0);
      check("t4_nr_sticky", bus.o_norespond, 4'b0010);
      bus.i_clr_nr = 4'b0010;
      tick();
      bus.i_clr_nr = '0;
      check("t4_nr_cleared", bus.o_norespond, 0);
      check("t4_no_grant_yet", outs(), 0);
      tick();
      check("t4_regrant", outs(), ev(4'b0010, 1, 0, 0, 1));
      serve(2, 1'b0);
      check("t4_regrant_done", outs(), ev(4'b0010, 0, 4'b0010, 0, 1));
      bus.i_req = '0;
      tick();

      // Done coincident with timeout expiry counts as success.
      do_reset();
      bus.i_req = 4'b0001;
      tick();
      serve(T + 1, 1'b0);
      check("t5_coincide_done", outs(), ev(4'b0001, 0, 4'b0001, 0, 1));
      bus.i_req = '0;
      tick();

      // Reset during WAIT: all outputs clear, no completion afterwards.
      do_reset();
      bus.i_req = 4'b0001;
      for (int i = 0; i < 4; i++) tick();
      check("t5_in_wait", outs(), ev(4'b0001, 0, 0, 0, 1));
      i_rst = 1'b1;
      tick();
      check("t5_rst_outs", outs(), 0);
      check("t5_rst_addr", {bus.o_rw, bus.o_addr}, 0);
      i_rst     = 1'b0;
      bus.i_req = '0;
      tick();
      check("t5_no_done", outs(), 0);

      // Randomised traffic against the behavioural model.
      do_reset();
      req_d = '0; rw_d = '0; clr_d = '0; clr_prev = '0; nr_m = '0; prev_e = '0;
      for (int k = 0; k < N; k++) begin
         addr_d[k] = '0;
         dead[k]   = 1'b0;
      end
      bus.i_addr = '0;
      bus.i_rw   = '0;
      g = -1; rr_m = 0; fails = 0; cyc = 0; start_cyc = -1; done_cyc = -1;
      drv_cyc = -1; wait_lo = 0; wait_hi = -1; skip_idle = 1'b0; exp_err = 1'b0;
      for (int n = 0; n < 5000; n++) begin
         int done_k;
         tick();
         cyc++;
         set_v  = '0;
         done_k = -1;
         if (g < 0) begin
            if (skip_idle) begin
               check("rnd_after_done", outs(), 0);
               skip_idle = 1'b0;
            end else if (prev_e != 0) begin
               g        = pick(prev_e, rr_m);
               fails    = 0;
               exp_addr = addr_d[g];
               exp_rw   = rw_d[g];
               check("rnd_grant", outs(), ev(oh(g), 1, 0, 0, 1));
               check("rnd_addr", {bus.o_rw, bus.o_addr}, {exp_rw, exp_addr});
               plan_attempt();
            end else begin
               check("rnd_idle", outs(), 0);
            end
         end else if (cyc == done_cyc) begin
            check("rnd_done", outs(), ev(oh(g), 0, oh(g), exp_err ? oh(g) : '0, 1));
            if (exp_err) set_v = oh(g);
            rr_m      = (g + 1) % N;
            done_k    = g;
            g         = -1;
            skip_idle = 1'b1;
         end else if (cyc == start_cyc) begin
            check("rnd_restart", outs(), ev(oh(g), 1, 0, 0, 1));
            check("rnd_addr_hold", {bus.o_rw, bus.o_addr}, {exp_rw, exp_addr});
            plan_attempt();
         end else begin
            check("rnd_hold", outs(), ev(oh(g), 0, 0, 0, 1));
         end
         nr_m = (nr_m & ~clr_prev) | set_v;
         check("rnd_norespond", bus.o_norespond, nr_m);

         // Requesters: drop on completion, occasionally abandon, raise new.
         if (done_k >= 0) req_d[done_k] = 1'b0;
         if (g >= 0 && req_d[g] && $urandom_range(0, 59) == 0) begin
            req_d[g]  = 1'b0;
            addr_d[g] = 7'($urandom);
            rw_d[g]   = 1'($urandom);
         end
         for (int k = 0; k < N; k++) begin
            if (!req_d[k] && k != g && k != done_k && $urandom_range(0, 4) == 0) begin
               req_d[k]  = 1'b1;
               addr_d[k] = 7'($urandom);
               rw_d[k]   = 1'($urandom);
               dead[k]   = ($urandom_range(0, 7) == 0);
            end
         end
         for (int k = 0; k < N; k++) bus.i_addr[7*k +: 7] = addr_d[k];
         bus.i_req = req_d;
         bus.i_rw  = rw_d;

         // Engine: real answer inside the WAIT window, noise outside it.
         if (g >= 0 && cyc == drv_cyc) begin
            bus.i_eng_done = 1'b1;
            bus.i_eng_nack = drv_nack;
         end else if ((g < 0 || cyc < wait_lo || cyc > wait_hi) && $urandom_range(0, 7) == 0) begin
            bus.i_eng_done = 1'b1;
            bus.i_eng_nack = 1'($urandom);
         end else begin
            bus.i_eng_done = 1'b0;
            bus.i_eng_nack = 1'($urandom);
         end

         clr_d        = ($urandom_range(0, 29) == 0) ? oh($urandom_range(0, N - 1)) : '0;
         bus.i_clr_nr = clr_d;
         clr_prev     = clr_d;
         prev_e       = req_d & ~nr_m;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
